zilla_imem_port_arbiter: RTL and testbench
==========================================

Name: zilla_imem_port_arbiter

Overview:
- Single-port arbiter in front of the Zilla instruction memory SRAM interface (z_im_* bus).
- Shares the port between the core fetch unit (read-only) and the debug module's memory access path (read/write with byte strobes).
- Tracks 1-cycle SRAM read latency, routes read data to the owner, supports fetch flush on redirect, and bounds debug starvation of fetch while the core runs.

Parameters:
PC_WIDTH, 20, fetch address width
INSTRUCTION_WIDTH, 32, fetch data width returned to decode
DATA_WIDTH, 64, SRAM data width (32 or 64)
MAX_DBG_BURST, 4, max consecutive debug grants while fetch waits outside debug mode; must be >=1

Ports:
ima_clk  in  1  clock
ima_rst  in  1  asynchronous active-low reset
debug_mode_valid_i  in  1  hart halted in debug mode
fetch_req_i  in  1  fetch read request
fetch_addr_i  in  PC_WIDTH  fetch byte address
fetch_flush_i  in  1  kill in-flight fetch response
fetch_gnt_o  out  1  fetch request accepted this cycle
fetch_rvalid_o  out  1  fetch data valid
fetch_rdata_o  out  INSTRUCTION_WIDTH  instruction word
dbg_req_i  in  1  debug access request
dbg_we_i  in  1  1=write, 0=read
dbg_addr_i  in  20  debug byte address
dbg_wdata_i  in  DATA_WIDTH  write data
dbg_strb_i  in  DATA_WIDTH/8  byte strobes
dbg_gnt_o  out  1  debug request accepted
dbg_rvalid_o  out  1  debug read data valid
dbg_rdata_o  out  DATA_WIDTH  debug read data
dbg_wack_o  out  1  debug write completed
z_im_read_en_o  out  1  SRAM read enable
z_im_read_addr_o  out  20  SRAM read address
z_im_read_data_i  in  DATA_WIDTH  SRAM read data, valid cycle after read_en
z_im_write_en_o  out  1  SRAM write enable
z_im_write_addr_o  out  20  SRAM write address
z_im_write_data_o  out  DATA_WIDTH  SRAM write data
z_im_write_data_strobe_o  out  DATA_WIDTH/8  SRAM strobes
arb_state_o  out  2  owner of previous-cycle grant (00 none, 01 fetch, 10 debug read, 11 debug write)
perf_conflict_cnt_o  out  32  cycles with both requests
perf_forced_fetch_cnt_o  out  32  starvation-guard grants

Behaviour:
- Reset: state=00, burst counter=0, all rvalid/wack=0, perf counters=0; gnt_o and z_im_*_en_o forced 0 while ima_rst low. All z_im address/data/strobe outputs are 0 when the corresponding enable is 0.
- Grants combinational, at most one per cycle; a grant drives SRAM signals in the same cycle.
- debug_mode_valid_i=1: debug strict priority; fetch never granted.
- debug_mode_valid_i=0: debug wins a conflict unless burst counter==MAX_DBG_BURST, then fetch wins and counter clears.
- Burst counter: increments on each debug grant while fetch_req_i=1 and debug mode off; clears on fetch grant, when fetch_req_i=0, or on entering debug mode; saturates at MAX_DBG_BURST.
- FSM (arb_state_o) registers the owner of each grant. Response cycle N+1 after a read grant at N: state 01 -> fetch_rvalid_o=1; 10 -> dbg_rvalid_o=1, dbg_rdata_o=z_im_read_data_i. Write grant at N -> state 11, dbg_wack_o=1 at N+1. Any state moves to the new grant's state each cycle (back-to-back grants allowed, full throughput).
- Fetch data: DATA_WIDTH=64 selects [63:32] if registered fetch_addr bit2=1, else [31:0]; DATA_WIDTH=32 passes [31:0].
- fetch_flush_i in cycle N suppresses fetch_rvalid_o for a fetch granted at N-1; a fetch granted in cycle N itself (redirect target) responds normally.
- Debug-mode entry with fetch in flight: response still delivered unless flushed.
- rvalid/wack are single-cycle pulses; no backpressure on responses.
- Reset mid-operation: pending responses discarded, no rvalid/wack after release.

Optional Feature:
ZILLA_IMEM_ARB_PERF_EN: defined -> perf_conflict_cnt_o increments each cycle fetch_req_i&&dbg_req_i; perf_forced_fetch_cnt_o increments on each starvation-guard fetch grant; both saturate at 32'hFFFFFFFF. Undefined -> both ports tied to 0, no counter flops.

Test Plan:
- Debug mode on, fetch_req and dbg read to 0x08000 each cycle -> only dbg_gnt_o; dbg_rvalid_o one cycle later with SRAM data; fetch_gnt_o never 1.
- Debug mode off, MAX_DBG_BURST=4, both requests held -> grant sequence D,D,D,D,F repeating; perf_forced_fetch_cnt_o=1 after 5 cycles.
- Fetch to addr 0x8004, SRAM returns 64'h11112222_33334444 -> fetch_rdata_o=32'h11112222, fetch_rvalid_o=1 next cycle.
- Fetch granted at N, fetch_flush_i at N+1 with new fetch granted at N+1 -> no rvalid at N+1; rvalid at N+2 for redirected fetch.
- Debug write addr 0x8000, strb 8'h0F, data 64'hDEADBEEF -> z_im_write_en_o=1, strobe 0x0F same cycle; dbg_wack_o pulse next cycle; arb_state_o=11.
- Reset asserted the cycle after a debug read grant -> dbg_rvalid_o stays 0, all counters 0 after release.

Source files
------------

// File: rtl/zilla_imem_port_arbiter.sv
// Single-port arbiter sharing the Zilla instruction SRAM between fetch (read-only) and debug (read/write).
// Optional perf counters are built only when ZILLA_IMEM_ARB_PERF_EN is defined.
module zilla_imem_port_arbiter #(
    parameter int PC_WIDTH          = 20,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int DATA_WIDTH        = 64,
    parameter int MAX_DBG_BURST     = 4
) (
    input  logic                         ima_clk,
    input  logic                         ima_rst,
    input  logic                         debug_mode_valid_i,
    input  logic                         fetch_req_i,
    input  logic [PC_WIDTH-1:0]          fetch_addr_i,
    input  logic                         fetch_flush_i,
    output logic                         fetch_gnt_o,
    output logic                         fetch_rvalid_o,
    output logic [INSTRUCTION_WIDTH-1:0] fetch_rdata_o,
    input  logic                         dbg_req_i,
    input  logic                         dbg_we_i,
    input  logic [19:0]                  dbg_addr_i,
    input  logic [DATA_WIDTH-1:0]        dbg_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]      dbg_strb_i,
    output logic                         dbg_gnt_o,
    output logic                         dbg_rvalid_o,
    output logic [DATA_WIDTH-1:0]        dbg_rdata_o,
    output logic                         dbg_wack_o,
    output logic                         z_im_read_en_o,
    output logic [19:0]                  z_im_read_addr_o,
    input  logic [DATA_WIDTH-1:0]        z_im_read_data_i,
    output logic                         z_im_write_en_o,
    output logic [19:0]                  z_im_write_addr_o,
    output logic [DATA_WIDTH-1:0]        z_im_write_data_o,
    output logic [DATA_WIDTH/8-1:0]      z_im_write_data_strobe_o,
    output logic [1:0]                   arb_state_o,
    output logic [31:0]                  perf_conflict_cnt_o,
    output logic [31:0]                  perf_forced_fetch_cnt_o
);

    localparam int BW = $clog2(MAX_DBG_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DBG_BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DRD   = 2'b10,
        ST_DWR   = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          burst_full;
    logic          fetch_gnt, dbg_gnt;
    logic          fetch_sel_q;
    logic [19:0]   fetch_addr20;

    function automatic logic [BW-1:0] burst_inc(input logic [BW-1:0] v);
        return (v == BURST_MAX) ? v : v + BW'(1);
    endfunction

    generate
        if (PC_WIDTH >= 20) begin : g_addr_trunc
            assign fetch_addr20 = fetch_addr_i[19:0];
        end else begin : g_addr_ext
            assign fetch_addr20 = {{(20-PC_WIDTH){1'b0}}, fetch_addr_i};
        end
    endgenerate

    // Arbitration: debug has priority except when the starvation guard lets a waiting fetch through.
    always_comb begin
        burst_full = (burst_q == BURST_MAX);
        fetch_gnt  = ima_rst && fetch_req_i && !debug_mode_valid_i && (!dbg_req_i || burst_full);
        dbg_gnt    = ima_rst && dbg_req_i && !fetch_gnt;

        state_d = ST_IDLE;
        if (fetch_gnt)    state_d = ST_FETCH;
        else if (dbg_gnt) state_d = dbg_we_i ? ST_DWR : ST_DRD;

        burst_d = burst_q;
        if (debug_mode_valid_i || !fetch_req_i || fetch_gnt) burst_d = '0;
        else if (dbg_gnt)                                    burst_d = burst_inc(burst_q);

        z_im_read_en_o           = 1'b0;
        z_im_read_addr_o         = '0;
        z_im_write_en_o          = 1'b0;
        z_im_write_addr_o        = '0;
        z_im_write_data_o        = '0;
        z_im_write_data_strobe_o = '0;
        if (fetch_gnt) begin
            z_im_read_en_o   = 1'b1;
            z_im_read_addr_o = fetch_addr20;
        end else if (dbg_gnt && !dbg_we_i) begin
            z_im_read_en_o   = 1'b1;
            z_im_read_addr_o = dbg_addr_i;
        end else if (dbg_gnt) begin
            z_im_write_en_o          = 1'b1;
            z_im_write_addr_o        = dbg_addr_i;
            z_im_write_data_o        = dbg_wdata_i;
            z_im_write_data_strobe_o = dbg_strb_i;
        end
    end

    always_ff @(posedge ima_clk or negedge ima_rst) begin
        if (!ima_rst) begin
            state_q <= ST_IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    // Word select for the returning fetch; only meaningful while state_q is ST_FETCH.
    always_ff @(posedge ima_clk) begin
        if (fetch_gnt) fetch_sel_q <= fetch_addr20[2];
    end

    assign fetch_gnt_o    = fetch_gnt;
    assign dbg_gnt_o      = dbg_gnt;
    assign arb_state_o    = state_q;
    assign fetch_rvalid_o = (state_q == ST_FETCH) && !fetch_flush_i;
    assign dbg_rvalid_o   = (state_q == ST_DRD);
    assign dbg_rdata_o    = dbg_rvalid_o ? z_im_read_data_i : '0;
    assign dbg_wack_o     = (state_q == ST_DWR);

    generate
        if (DATA_WIDTH == 64) begin : g_dw64
            assign fetch_rdata_o = fetch_sel_q ? z_im_read_data_i[63:32] : z_im_read_data_i[31:0];
        end else begin : g_dw32
            assign fetch_rdata_o = z_im_read_data_i[31:0];
        end
    endgenerate

`ifdef ZILLA_IMEM_ARB_PERF_EN
    logic [31:0] conflict_cnt_q, forced_cnt_q;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge ima_clk or negedge ima_rst) begin
        if (!ima_rst) begin
            conflict_cnt_q <= '0;
            forced_cnt_q   <= '0;
        end else begin
            if (fetch_req_i && dbg_req_i) conflict_cnt_q <= sat_inc32(conflict_cnt_q);
            if (fetch_gnt && dbg_req_i)   forced_cnt_q   <= sat_inc32(forced_cnt_q);
        end
    end

    assign perf_conflict_cnt_o     = conflict_cnt_q;
    assign perf_forced_fetch_cnt_o = forced_cnt_q;
`else
    assign perf_conflict_cnt_o     = '0;
    assign perf_forced_fetch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_zilla_imem_port_arbiter.sv
// Scoreboard bench for zilla_imem_port_arbiter: directed scenarios followed by randomized traffic.
module tb_zilla_imem_port_arbiter;

    localparam int MAXB = 4;
    localparam int K_NONE = 0, K_F = 1, K_DR = 2, K_DW = 3;

    logic        ima_clk = 1'b0;
    logic        ima_rst;
    logic        debug_mode_valid_i, fetch_req_i, fetch_flush_i;
    logic [19:0] fetch_addr_i;
    logic        fetch_gnt_o, fetch_rvalid_o;
    logic [31:0] fetch_rdata_o;
    logic        dbg_req_i, dbg_we_i;
    logic [19:0] dbg_addr_i;
    logic [63:0] dbg_wdata_i;
    logic [7:0]  dbg_strb_i;
    logic        dbg_gnt_o, dbg_rvalid_o, dbg_wack_o;
    logic [63:0] dbg_rdata_o;
    logic        z_im_read_en_o, z_im_write_en_o;
    logic [19:0] z_im_read_addr_o, z_im_write_addr_o;
    logic [63:0] z_im_read_data_i, z_im_write_data_o;
    logic [7:0]  z_im_write_data_strobe_o;
    logic [1:0]  arb_state_o;
    logic [31:0] perf_conflict_cnt_o, perf_forced_fetch_cnt_o;

    zilla_imem_port_arbiter #(.PC_WIDTH(20), .INSTRUCTION_WIDTH(32), .DATA_WIDTH(64), .MAX_DBG_BURST(MAXB)) dut (
        .ima_clk(ima_clk), .ima_rst(ima_rst), .debug_mode_valid_i(debug_mode_valid_i),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_flush_i(fetch_flush_i),
        .fetch_gnt_o(fetch_gnt_o), .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_strb_i(dbg_strb_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
        .dbg_wack_o(dbg_wack_o), .z_im_read_en_o(z_im_read_en_o), .z_im_read_addr_o(z_im_read_addr_o),
        .z_im_read_data_i(z_im_read_data_i), .z_im_write_en_o(z_im_write_en_o),
        .z_im_write_addr_o(z_im_write_addr_o), .z_im_write_data_o(z_im_write_data_o),
        .z_im_write_data_strobe_o(z_im_write_data_strobe_o), .arb_state_o(arb_state_o),
        .perf_conflict_cnt_o(perf_conflict_cnt_o), .perf_forced_fetch_cnt_o(perf_forced_fetch_cnt_o)
    );

    always #5 ima_clk = ~ima_clk;

    typedef struct { int due; int kind; logic [63:0] data; } exp_t;
    exp_t        sb[$];
    int          checks = 0, failures = 0, cyc = 0;
    int          m_burst = 0, m_owner = K_NONE;
    logic [31:0] m_conf = 0, m_forced = 0;
    logic [63:0] sram_plan = 64'h0, force_plan = 64'h0;
    bit          force_plan_v = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: drive inputs at negedge, predict the grant, check same-cycle outputs, queue the response.
    task automatic step(input logic rst, dm, freq, input logic [19:0] fa, input logic fl,
                        input logic dreq, dwe, input logic [19:0] da, input logic [63:0] wd,
                        input logic [7:0] st);
        int          win;
        logic        e_ren, e_wen;
        logic [19:0] e_raddr, e_waddr;
        logic [63:0] e_wdata;
        logic [7:0]  e_strb;
        exp_t        e;
        @(negedge ima_clk);
        cyc++;
        ima_rst = rst; debug_mode_valid_i = dm; fetch_req_i = freq; fetch_addr_i = fa;
        fetch_flush_i = fl; dbg_req_i = dreq; dbg_we_i = dwe; dbg_addr_i = da;
        dbg_wdata_i = wd; dbg_strb_i = st;
        z_im_read_data_i = sram_plan;
        sram_plan = {$urandom, $urandom};
        if (force_plan_v) begin sram_plan = force_plan; force_plan_v = 0; end
        win = K_NONE;
        if (!rst) begin
            sb.delete(); m_burst = 0; m_owner = K_NONE; m_conf = 0; m_forced = 0;
        end else begin
            if (fl && sb.size() > 0 && sb[0].due == cyc && sb[0].kind == K_F) sb.delete(0);
            if (dm)                   win = dreq ? (dwe ? K_DW : K_DR) : K_NONE;
            else if (freq && dreq)    win = (m_burst == MAXB) ? K_F : (dwe ? K_DW : K_DR);
            else if (freq)            win = K_F;
            else if (dreq)            win = dwe ? K_DW : K_DR;
        end
        e_ren   = (win == K_F) || (win == K_DR);
        e_raddr = (win == K_F) ? fa : (win == K_DR) ? da : 20'h0;
        e_wen   = (win == K_DW);
        e_waddr = e_wen ? da : 20'h0;
        e_wdata = e_wen ? wd : 64'h0;
        e_strb  = e_wen ? st : 8'h0;
        #1;
        check("fetch_gnt", fetch_gnt_o, win == K_F);
        check("dbg_gnt", dbg_gnt_o, win == K_DR || win == K_DW);
        check("rd_en", z_im_read_en_o, e_ren);
        check("rd_addr", z_im_read_addr_o, e_raddr);
        check("wr_en", z_im_write_en_o, e_wen);
        check("wr_addr", z_im_write_addr_o, e_waddr);
        check("wr_data", z_im_write_data_o, e_wdata);
        check("wr_strb", z_im_write_data_strobe_o, e_strb);
        check("arb_state", arb_state_o, m_owner[1:0]);
`ifdef ZILLA_IMEM_ARB_PERF_EN
        check("perf_conflict", perf_conflict_cnt_o, m_conf);
        check("perf_forced", perf_forced_fetch_cnt_o, m_forced);
`else
        check("perf_conflict", perf_conflict_cnt_o, 0);
        check("perf_forced", perf_forced_fetch_cnt_o, 0);
`endif
        if (rst) begin
            m_owner = win;
            if (win != K_NONE) begin
                e.due = cyc + 1; e.kind = win; e.data = 64'h0;
                if (win == K_F)  e.data = {32'h0, fa[2] ? sram_plan[63:32] : sram_plan[31:0]};
                if (win == K_DR) e.data = sram_plan;
                sb.push_back(e);
            end
            if (freq && dreq) m_conf++;
            if (win == K_F && dreq) m_forced++;
            if (dm || !freq || win == K_F) m_burst = 0;
            else if (win == K_DR || win == K_DW) m_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
        end
    endtask

    // Response monitor: pops the expectation due this cycle and compares every response output.
    initial begin
        exp_t e;
        logic [2:0] ev;
        forever begin
            @(negedge ima_clk);
            #2;
            ev = 3'b000; e.kind = K_NONE; e.data = 64'h0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                ev = {e.kind == K_F, e.kind == K_DR, e.kind == K_DW};
            end
            check("resp_valids", {fetch_rvalid_o, dbg_rvalid_o, dbg_wack_o}, ev);
            if (e.kind == K_F && fetch_rvalid_o) check("fetch_rdata", fetch_rdata_o, e.data[31:0]);
            if (e.kind == K_DR && dbg_rvalid_o)  check("dbg_rdata", dbg_rdata_o, e.data);
        end
    end

    initial begin
        ima_rst = 1'b1; debug_mode_valid_i = 0; fetch_req_i = 0; fetch_addr_i = 0; fetch_flush_i = 0;
        dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0; dbg_strb_i = 0; z_im_read_data_i = 0;
        #1 ima_rst = 1'b0;
        // Reset with requests pending: no grants, no enables.
        repeat (3) step(0, 0, 1, 20'h08000, 0, 1, 0, 20'h08000, 64'h0, 8'h0);
        // Debug mode: debug strict priority.
        repeat (4) step(1, 1, 1, 20'h08010, 0, 1, 0, 20'h08000, 64'h0, 8'h0);
        // Debug mode off, both held: D,D,D,D,F repeating.
        repeat (11) step(1, 0, 1, 20'h08020, 0, 1, 0, 20'h08008, 64'h0, 8'h0);
        step(1, 0, 0, 20'h0, 0, 0, 0, 20'h0, 64'h0, 8'h0);
        // Upper-word fetch select.
        force_plan = 64'h11112222_33334444; force_plan_v = 1;
        step(1, 0, 1, 20'h08004, 0, 0, 0, 20'h0, 64'h0, 8'h0);
        force_plan = 64'hAAAA5555_CCCC3333; force_plan_v = 1;
        step(1, 0, 1, 20'h08000, 0, 0, 0, 20'h0, 64'h0, 8'h0);
        // Flush kills the older fetch; redirect fetch responds.
        step(1, 0, 1, 20'h08100, 0, 0, 0, 20'h0, 64'h0, 8'h0);
        step(1, 0, 1, 20'h08204, 1, 0, 0, 20'h0, 64'h0, 8'h0);
        step(1, 0, 0, 20'h0, 0, 0, 0, 20'h0, 64'h0, 8'h0);
        // Debug write with partial strobes.
        step(1, 0, 0, 20'h0, 0, 1, 1, 20'h08000, 64'h00000000_DEADBEEF, 8'h0F);
        step(1, 0, 0, 20'h0, 0, 0, 0, 20'h0, 64'h0, 8'h0);
        // Fetch in flight across debug-mode entry.
        step(1, 0, 1, 20'h08300, 0, 0, 0, 20'h0, 64'h0, 8'h0);
        step(1, 1, 1, 20'h08304, 0, 1, 0, 20'h08040, 64'h0, 8'h0);
        // Reset right after a debug read grant discards its response.
        step(1, 0, 0, 20'h0, 0, 1, 0, 20'h08000, 64'h0, 8'h0);
        step(0, 0, 1, 20'h0, 0, 1, 0, 20'h08000, 64'h0, 8'h0);
        repeat (2) step(1, 0, 0, 20'h0, 0, 0, 0, 20'h0, 64'h0, 8'h0);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] r;
            r = $urandom;
            step($urandom_range(0, 199) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 {8'h08, r[11:0]}, $urandom_range(0, 7) == 0, r[12], r[13], {8'h08, r[27:16]},
                 {$urandom, $urandom}, r[31:24]);
        end
        repeat (2) step(1, 0, 0, 20'h0, 0, 0, 0, 20'h0, 64'h0, 8'h0);
        @(negedge ima_clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
